// File: rtl/keymat_pkg.sv
// ============================================================================
// Module : keymat_pkg
// Brief  : Shared geometry, key-index type and interrupt FSM encoding for the
//          keymat_responder switch-matrix peripheral.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package keymat_pkg;

    localparam int NCOL = 8;
    localparam int NROW = 4;
    localparam int NKEY = 32;

    typedef logic [4:0] key_idx_t;

    typedef enum logic [0:0] {
        INT_IDLE  = 1'b0,
        INT_PULSE = 1'b1
    } int_state_e;

    // Lowest set bit wins; returns 0 for an empty vector.
    function automatic key_idx_t lowest_set(input logic [NKEY-1:0] v);
        key_idx_t idx;
        idx = '0;
        for (int i = NKEY - 1; i >= 0; i--) begin
            if (v[i]) begin
                idx = key_idx_t'(i);
            end
        end
        return idx;
    endfunction

endpackage

`default_nettype wire

// File: rtl/keymat_debounce_cell.sv
// ============================================================================
// Module : keymat_debounce_cell
// Brief  : One key's debounce counter and debounced state; flips after
//          DEB_CNT consecutive disagreeing sample ticks.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module keymat_debounce_cell #(
    parameter int DEB_CNT = 3
) (
    input  logic clk,
    input  logic reset,
    input  logic tick,
    input  logic sample,
    output logic deb,
    output logic rise
);

    logic [2:0] r_cnt;
    logic       r_deb;
    logic       w_disagree;
    logic       w_flip;

    assign w_disagree = sample ^ r_deb;
    assign w_flip     = tick & w_disagree & (r_cnt == 3'(DEB_CNT - 1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt <= 3'd0;
            r_deb <= 1'b0;
        end else if (tick) begin
            if (!w_disagree) begin
                r_cnt <= 3'd0;
            end else if (w_flip) begin
                r_deb <= ~r_deb;
                r_cnt <= 3'd0;
            end else if (r_cnt != 3'd7) begin
                r_cnt <= r_cnt + 3'd1;
            end
        end
    end

    assign deb  = r_deb;
    assign rise = w_flip & ~r_deb;

endmodule

`default_nettype wire

// File: rtl/keymat_responder.sv
// ============================================================================
// Module : keymat_responder
// Brief  : Debounced 8x4 key matrix answering the MCU strobe/read cycle, with
//          press-event key code and active-low interrupt pulse.
//          Optional: KEYMAT_GHOST_MASK_EN suppresses ghost-ambiguous presses.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module keymat_responder
    import keymat_pkg::*;
#(
    parameter int SAMPLE_DIV = 256,
    parameter int DEB_CNT    = 3,
    parameter int INT_LEN    = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [7:0]  strobe,
    input  logic [31:0] keys_raw,
    output logic [3:0]  row_data,
    output logic        int_n,
    output logic [5:0]  key_code,
    input  logic        code_ack
);

    localparam int         c_DIV_W    = $clog2(SAMPLE_DIV);
    localparam int         c_ILEN_W   = $clog2(INT_LEN);
    localparam logic [0:0] c_ST_IDLE  = 1'(INT_IDLE);
    localparam logic [0:0] c_ST_PULSE = 1'(INT_PULSE);

    logic [NKEY-1:0]     r_sync1;
    logic [NKEY-1:0]     r_sync2;
    logic [c_DIV_W-1:0]  r_div;
    logic                w_tick;
    logic [NKEY-1:0]     w_deb;
    logic [NKEY-1:0]     w_rise;
    logic [NKEY-1:0]     w_press_vec;
    logic                w_press;
    key_idx_t            w_press_idx;
    logic [NROW-1:0]     w_row;
    logic [NROW-1:0]     r_row_data;
    logic [5:0]          r_key_code;
    logic [0:0]          r_int_state;
    logic [c_ILEN_W-1:0] r_int_cnt;
    logic                r_int_n;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= '0;
            r_sync2 <= '0;
        end else begin
            r_sync1 <= keys_raw;
            r_sync2 <= r_sync1;
        end
    end

    assign w_tick = (r_div == c_DIV_W'(SAMPLE_DIV - 1));

    always_ff @(posedge clk) begin
        if (reset || w_tick) begin
            r_div <= '0;
        end else begin
            r_div <= r_div + 1'b1;
        end
    end

    generate
        for (genvar k = 0; k < NKEY; k++) begin : g_key
            keymat_debounce_cell #(
                .DEB_CNT (DEB_CNT)
            ) u_cell (
                .clk    (clk),
                .reset  (reset),
                .tick   (w_tick),
                .sample (r_sync2[k]),
                .deb    (w_deb[k]),
                .rise   (w_rise[k])
            );
        end
    endgenerate

    always_comb begin
        w_row = '0;
        for (int c = 0; c < NCOL; c++) begin
            for (int r = 0; r < NROW; r++) begin
                w_row[r] = w_row[r] | (strobe[c] & w_deb[c*NROW + r]);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_row_data <= '0;
        end else begin
            r_row_data <= w_row;
        end
    end

`ifdef KEYMAT_GHOST_MASK_EN
    logic [NKEY-1:0] w_deb_nxt;
    logic [NCOL-1:0] w_amb;
    logic [NROW-1:0] w_col_c;

    // Ambiguity is judged on the state as it will be after this tick, so a
    // key completing a ghost rectangle is itself masked.
    always_comb begin
        w_deb_nxt = w_deb | w_rise;
        w_amb     = '0;
        w_col_c   = '0;
        for (int c = 0; c < NCOL; c++) begin
            w_col_c = w_deb_nxt[c*NROW +: NROW];
            for (int d = 0; d < NCOL; d++) begin
                if ((d != c) && ((w_col_c & (w_col_c - 4'd1)) != '0) &&
                    ((w_col_c & w_deb_nxt[d*NROW +: NROW]) != '0)) begin
                    w_amb[c] = 1'b1;
                end
            end
        end
        for (int k = 0; k < NKEY; k++) begin
            w_press_vec[k] = w_rise[k] & ~w_amb[k/NROW];
        end
    end
`else
    assign w_press_vec = w_rise;
`endif

    assign w_press     = |w_press_vec;
    assign w_press_idx = lowest_set(w_press_vec);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_key_code <= '0;
        end else if (w_press) begin
            r_key_code <= {1'b1, w_press_idx};
        end else if (code_ack) begin
            r_key_code[5] <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_int_state <= c_ST_IDLE;
            r_int_cnt   <= '0;
            r_int_n     <= 1'b1;
        end else begin
            case (r_int_state)
                c_ST_IDLE: begin
                    if (w_press) begin
                        r_int_state <= c_ST_PULSE;
                        r_int_cnt   <= c_ILEN_W'(INT_LEN - 1);
                        r_int_n     <= 1'b0;
                    end
                end
                c_ST_PULSE: begin
                    if (w_press) begin
                        r_int_cnt <= c_ILEN_W'(INT_LEN - 1);
                    end else if (r_int_cnt == '0) begin
                        r_int_state <= c_ST_IDLE;
                        r_int_n     <= 1'b1;
                    end else begin
                        r_int_cnt <= r_int_cnt - 1'b1;
                    end
                end
                default: begin
                    r_int_state <= c_ST_IDLE;
                    r_int_n     <= 1'b1;
                end
            endcase
        end
    end

    assign row_data = r_row_data;
    assign key_code = r_key_code;
    assign int_n    = r_int_n;

endmodule

`default_nettype wire

// File: tb/tb_keymat_responder.sv
// ============================================================================
// Module : tb_keymat_responder
// Brief  : Scoreboard bench for keymat_responder: expected key codes and
//          interrupt low-lengths are queued with stimulus, checked on output.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_keymat_responder;

    localparam int c_SD   = 3;
    localparam int c_DEB  = 3;
    localparam int c_ILEN = 8;

    logic        clk;
    logic        reset;
    logic [7:0]  strobe;
    logic [31:0] keys_raw;
    logic [3:0]  row_data;
    logic        int_n;
    logic [5:0]  key_code;
    logic        code_ack;

    int          n_vec;
    int          n_miss;
    logic [5:0]  code_q[$];
    int          len_q[$];
    logic [5:0]  prev_kc;
    int          lowcnt;
    int          tb_div;

    keymat_responder #(
        .SAMPLE_DIV (c_SD),
        .DEB_CNT    (c_DEB),
        .INT_LEN    (c_ILEN)
    ) u_dut (
        .clk      (clk),
        .reset    (reset),
        .strobe   (strobe),
        .keys_raw (keys_raw),
        .row_data (row_data),
        .int_n    (int_n),
        .key_code (key_code),
        .code_ack (code_ack)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Bench-side prescaler model, used only to align stimulus with sample ticks.
    always @(posedge clk) begin
        if (reset) tb_div <= 0;
        else       tb_div <= (tb_div == c_SD - 1) ? 0 : tb_div + 1;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Output monitor: pops expectations as events and interrupt pulses appear.
    initial begin
        prev_kc = '0;
        lowcnt  = 0;
        forever begin
            @(negedge clk);
            if (key_code[5] === 1'b1 && key_code !== prev_kc) begin
                if (code_q.size() == 0) check("unexpected_code", {26'd0, key_code}, 32'd0);
                else                    check("event_code", {26'd0, key_code}, {26'd0, code_q.pop_front()});
            end
            prev_kc = key_code;
            if (int_n === 1'b0) begin
                lowcnt++;
            end else if (lowcnt > 0) begin
                if (len_q.size() == 0) check("unexpected_int_len", lowcnt, 0);
                else                   check("int_low_len", lowcnt, len_q.pop_front());
                lowcnt = 0;
            end
        end
    end

    // Returns at the negedge just after a sample-tick posedge.
    task automatic align_tick();
        for (int i = 0; i < c_SD + 2 && tb_div != c_SD - 1; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic wait_drain(input int max_cyc);
        for (int i = 0; i < max_cyc; i++) begin
            if (code_q.size() == 0 && len_q.size() == 0 && int_n === 1'b1) break;
            @(negedge clk);
        end
        @(negedge clk);
        check("drain", code_q.size() + len_q.size(), 0);
    endtask

    // Called at the negedge reset drops: no event may precede the DEB_CNT-th tick.
    task automatic release_and_check_quiet();
        reset = 1'b0;
        repeat (c_SD * c_DEB - 1) @(negedge clk);
        check("pre_flip_code", {26'd0, key_code}, 32'd0);
        check("pre_flip_int", {31'd0, int_n}, 32'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: timeout reached, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        n_vec    = 0;
        n_miss   = 0;
        reset    = 1'b1;
        keys_raw = 32'hFFFF_FFFF;
        strobe   = 8'hFF;
        code_ack = 1'b0;

        // Reset state with every key pressed, then debounce-in of all keys.
        repeat (4) @(negedge clk);
        check("rst_row_data", {28'd0, row_data}, 32'd0);
        check("rst_int_n", {31'd0, int_n}, 32'd1);
        check("rst_key_code", {26'd0, key_code}, 32'd0);
`ifndef KEYMAT_GHOST_MASK_EN
        code_q.push_back(6'b1_00000);
        len_q.push_back(c_ILEN);
`endif
        release_and_check_quiet();
        wait_drain(40);
        check("all_rows_ff", {28'd0, row_data}, 32'hF);
        keys_raw = '0;
        repeat (c_SD * c_DEB + 6) @(negedge clk);
        check("all_released", {28'd0, row_data}, 32'd0);

        // Single key 9 (col2,row1).
        strobe   = 8'h04;
        keys_raw = 32'd1 << 9;
        code_q.push_back(6'b1_01001);
        len_q.push_back(c_ILEN);
        wait_drain(60);
        check("k9_row", {28'd0, row_data}, 32'b0010);
        check("k9_code", {26'd0, key_code}, 32'b1_01001);
        code_ack = 1'b1;
        @(negedge clk);
        code_ack = 1'b0;
        check("ack_clear", {26'd0, key_code}, 32'b0_01001);
        code_ack = 1'b1;
        @(negedge clk);
        code_ack = 1'b0;
        @(negedge clk);
        check("ack_idle", {26'd0, key_code}, 32'b0_01001);
        keys_raw = '0;
        repeat (c_SD * c_DEB + 6) @(negedge clk);
        check("k9_release", {28'd0, row_data}, 32'd0);

        // Bounce 1,0,1 across ticks never reaches DEB_CNT agreeing samples.
        align_tick(); keys_raw = 32'd1 << 9;
        align_tick(); keys_raw = '0;
        align_tick(); keys_raw = 32'd1 << 9;
        align_tick(); keys_raw = '0;
        repeat (4 * c_SD) @(negedge clk);
        check("bounce_row", {28'd0, row_data}, 32'd0);
        check("bounce_code", {26'd0, key_code}, 32'b0_01001);
        check("bounce_int", {31'd0, int_n}, 32'd1);

        // Keys 5 and 20 on one tick, key 12 one tick later extends the pulse.
        align_tick();
        keys_raw = (32'd1 << 5) | (32'd1 << 20);
        code_q.push_back(6'b1_00101);
        len_q.push_back(3 + c_ILEN);
        align_tick();
        keys_raw = keys_raw | (32'd1 << 12);
        code_q.push_back(6'b1_01100);
        wait_drain(60);
        strobe = 8'hFF; @(negedge clk);
        check("strobe_ff", {28'd0, row_data}, 32'b0011);
        strobe = 8'h00; @(negedge clk);
        check("strobe_00", {28'd0, row_data}, 32'd0);
        strobe = 8'h20; @(negedge clk);
        check("strobe_col5", {28'd0, row_data}, 32'b0001);
        strobe = 8'h02; @(negedge clk);
        check("strobe_col1", {28'd0, row_data}, 32'b0010);

        // code_ack coinciding with key 31's press: the press wins.
        align_tick();
        keys_raw = keys_raw | (32'd1 << 31);
        code_q.push_back(6'b1_11111);
        len_q.push_back(c_ILEN);
        repeat (c_SD * c_DEB - 1) @(negedge clk);
        code_ack = 1'b1;
        @(negedge clk);
        code_ack = 1'b0;
        check("ack_vs_press", {26'd0, key_code}, 32'b1_11111);
        wait_drain(40);

        // Reset three cycles into a pulse aborts it; held keys re-debounce.
        align_tick();
        keys_raw = keys_raw | (32'd1 << 2);
        code_q.push_back(6'b1_00010);
        len_q.push_back(3);
        repeat (c_SD * c_DEB - 1 + 3) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        check("midrst_int_n", {31'd0, int_n}, 32'd1);
        check("midrst_code", {26'd0, key_code}, 32'd0);
        check("midrst_row", {28'd0, row_data}, 32'd0);
        code_q.push_back(6'b1_00010);
        len_q.push_back(c_ILEN);
        @(negedge clk);
        release_and_check_quiet();
        wait_drain(40);

`ifdef KEYMAT_GHOST_MASK_EN
        // Keys 0,1,4: 0 and 1 are ambiguous, 4 is not; then key 5 is masked.
        keys_raw = '0;
        reset    = 1'b1;
        repeat (2) @(negedge clk);
        reset    = 1'b0;
        keys_raw = (32'd1 << 0) | (32'd1 << 1) | (32'd1 << 4);
        code_q.push_back(6'b1_00100);
        len_q.push_back(c_ILEN);
        wait_drain(40);
        align_tick();
        keys_raw = keys_raw | (32'd1 << 5);
        repeat (c_SD * c_DEB + 6) @(negedge clk);
        check("ghost_code", {26'd0, key_code}, 32'b1_00100);
        check("ghost_int", {31'd0, int_n}, 32'd1);
`endif

        check("queues_empty", code_q.size() + len_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

`default_nettype wire
